// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO and its storage.
package sync_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;
    localparam int MEM_INIT_VAL   = 0;

    // Ceiling log2; returns the address width needed for `value` entries.
    function automatic int clogb2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/simple_dual_port_2_clock_ram.sv
// Simple dual-port RAM: one write port, one registered read port, independent clocks.
module simple_dual_port_2_clock_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter     RAM_STYLE  = "block"
) (
    input  logic                  wr_clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_clk_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    (* ram_style = RAM_STYLE *) logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge wr_clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Read-first: a same-edge write to the read address returns the old word.
    always_ff @(posedge rd_clk_i) begin
        if (rd_en_i) begin
            rd_data_o <= mem[rd_addr_i];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through read, fill count,
// almost-full/empty thresholds, overflow/underflow pulses and synchronous flush.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int FWFT          = FIFO_MODE_STD,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          clear_i,
    input  logic                          wr_i,
    input  logic [DATA_WIDTH-1:0]         data_i,
    input  logic                          rd_i,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic                          almost_full_o,
    output logic                          almost_empty_o,
    output logic [clogb2(FIFO_DEPTH):0]   count_o,
    output logic                          overflow_o,
    output logic                          underflow_o
);

    localparam int          AW       = clogb2(FIFO_DEPTH);
    localparam int          CW       = AW + 1;
    localparam logic [AW:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [AW:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [AW:0] AEMPTY_C = CW'(AEMPTY_THRESH);
    localparam logic [AW:0] ONE_C    = CW'(1);
    localparam bit          IS_FWFT  = (FWFT == FIFO_MODE_FWFT);

    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [AW:0]           count_next;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  ram_rd_en;
    logic                  ram_valid;
    logic                  ram_valid_next;
    logic                  load_out;
    logic                  out_valid_next;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    // Handshake: wr_i/rd_i are requests sampled every edge; a request is taken
    // only when wr_ok/rd_ok is true, otherwise it is dropped and flagged next cycle.
    always_comb begin
        rd_ok = rd_i && !empty_o;
        wr_ok = wr_i && (!full_o || rd_ok);

        count_next = count_o;
        if (wr_ok && !rd_ok) begin
            count_next = count_o + ONE_C;
        end else if (!wr_ok && rd_ok) begin
            count_next = count_o - ONE_C;
        end

        // ram_valid marks a word sitting in the RAM read register, not yet on data_o.
        if (IS_FWFT) begin
            load_out       = ram_valid && (empty_o || rd_ok);
            ram_rd_en      = (wr_ptr != rd_ptr) && (!ram_valid || load_out);
            out_valid_next = load_out || (!empty_o && !rd_ok);
        end else begin
            load_out       = ram_valid;
            ram_rd_en      = rd_ok;
            out_valid_next = (count_next != '0);
        end
        ram_valid_next = ram_rd_en || (ram_valid && !load_out);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            ram_valid      <= 1'b0;
            data_o         <= '0;
            count_o        <= '0;
            full_o         <= 1'b0;
            empty_o        <= 1'b1;
            almost_full_o  <= 1'b0;
            almost_empty_o <= 1'b1;
            overflow_o     <= 1'b0;
            underflow_o    <= 1'b0;
        end else if (clear_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            ram_valid      <= 1'b0;
            count_o        <= '0;
            full_o         <= 1'b0;
            empty_o        <= 1'b1;
            almost_full_o  <= 1'b0;
            almost_empty_o <= 1'b1;
            overflow_o     <= 1'b0;
            underflow_o    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ONE_C;
            end
            if (ram_rd_en) begin
                rd_ptr <= rd_ptr + ONE_C;
            end
            if (load_out) begin
                data_o <= ram_rd_data;
            end
            ram_valid      <= ram_valid_next;
            count_o        <= count_next;
            full_o         <= (count_next == DEPTH_C);
            empty_o        <= !out_valid_next;
            almost_full_o  <= (count_next >= AFULL_C);
            almost_empty_o <= (count_next <= AEMPTY_C);
            overflow_o     <= wr_i && !wr_ok;
            underflow_o    <= rd_i && !rd_ok;
        end
    end

    simple_dual_port_2_clock_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (AW),
        .RAM_STYLE  ("block")
    ) u_ram (
        .wr_clk_i  (clk_i),
        .wr_en_i   (wr_ok && !clear_i),
        .wr_addr_i (wr_ptr[AW-1:0]),
        .wr_data_i (data_i),
        .rd_clk_i  (clk_i),
        .rd_en_i   (ram_rd_en && !clear_i),
        .rd_addr_i (rd_ptr[AW-1:0]),
        .rd_data_o (ram_rd_data)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed and scoreboarded bench for sync_fifo in standard and FWFT modes.
module tb_sync_fifo;

    logic       clk;
    logic       rst_n;
    int         checks;
    int         failures;

    logic       s_clear, s_wr, s_rd;
    logic [7:0] s_din, s_dout;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic [4:0] s_count;

    logic       f_clear, f_wr, f_rd;
    logic [7:0] f_din, f_dout;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [4:0] f_count;

    sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FWFT(0)) u_std (
        .clk_i(clk), .rst_n_i(rst_n), .clear_i(s_clear), .wr_i(s_wr), .data_i(s_din),
        .rd_i(s_rd), .data_o(s_dout), .full_o(s_full), .empty_o(s_empty),
        .almost_full_o(s_af), .almost_empty_o(s_ae), .count_o(s_count),
        .overflow_o(s_ovf), .underflow_o(s_udf)
    );

    sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FWFT(1)) u_fwft (
        .clk_i(clk), .rst_n_i(rst_n), .clear_i(f_clear), .wr_i(f_wr), .data_i(f_din),
        .rd_i(f_rd), .data_o(f_dout), .full_o(f_full), .empty_o(f_empty),
        .almost_full_o(f_af), .almost_empty_o(f_ae), .count_o(f_count),
        .overflow_o(f_ovf), .underflow_o(f_udf)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic std_write(input logic [7:0] v);
        s_wr = 1'b1; s_din = v;
        tick();
        s_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_clear = 0; s_wr = 0; s_rd = 0; s_din = '0;
        f_clear = 0; f_wr = 0; f_rd = 0; f_din = '0;
        checks = 0; failures = 0;
        repeat (3) tick();
        checks++; if ({s_empty, s_full, s_ae, s_af, s_ovf, s_udf} !== 6'b101000) begin failures++; $display("FAIL rst_std_flags got=%b exp=101000", {s_empty, s_full, s_ae, s_af, s_ovf, s_udf}); end
        checks++; if (s_count !== 5'd0 || s_dout !== 8'h00) begin failures++; $display("FAIL rst_std_count_data got=%0d/%h exp=0/00", s_count, s_dout); end
        checks++; if ({f_empty, f_full, f_ae, f_af, f_ovf, f_udf} !== 6'b101000 || f_count !== 5'd0) begin failures++; $display("FAIL rst_fwft got=%b/%0d exp=101000/0", {f_empty, f_full, f_ae, f_af, f_ovf, f_udf}, f_count); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fwft();
        f_wr = 1'b1; f_din = 8'hA5;
        tick();
        f_wr = 1'b0;
        checks++; if (f_empty !== 1'b1 || f_count !== 5'd1) begin failures++; $display("FAIL fwft_n0 got=%b/%0d exp=1/1", f_empty, f_count); end
        tick();
        checks++; if (f_empty !== 1'b1) begin failures++; $display("FAIL fwft_n1_empty got=%b exp=1", f_empty); end
        tick();
        checks++; if (f_empty !== 1'b0 || f_dout !== 8'hA5) begin failures++; $display("FAIL fwft_n2 got=%b/%h exp=0/a5", f_empty, f_dout); end
        f_rd = 1'b1;
        tick();
        f_rd = 1'b0;
        checks++; if (f_empty !== 1'b1 || f_count !== 5'd0) begin failures++; $display("FAIL fwft_pop got=%b/%0d exp=1/0", f_empty, f_count); end
        f_rd = 1'b1;
        tick();
        f_rd = 1'b0;
        checks++; if (f_udf !== 1'b1) begin failures++; $display("FAIL fwft_udf got=%b exp=1", f_udf); end
        for (int i = 0; i < 3; i++) begin
            f_wr = 1'b1; f_din = 8'hB1 + 8'(i);
            tick();
        end
        f_wr = 1'b0;
        checks++; if (f_empty !== 1'b0 || f_dout !== 8'hB1 || f_count !== 5'd3) begin failures++; $display("FAIL fwft_burst_head got=%b/%h/%0d exp=0/b1/3", f_empty, f_dout, f_count); end
        repeat (2) tick();
        f_rd = 1'b1;
        tick();
        checks++; if (f_dout !== 8'hB2 || f_count !== 5'd2) begin failures++; $display("FAIL fwft_pop1 got=%h/%0d exp=b2/2", f_dout, f_count); end
        tick();
        checks++; if (f_dout !== 8'hB3 || f_empty !== 1'b0) begin failures++; $display("FAIL fwft_pop2 got=%h/%b exp=b3/0", f_dout, f_empty); end
        tick();
        f_rd = 1'b0;
        checks++; if (f_empty !== 1'b1 || f_count !== 5'd0) begin failures++; $display("FAIL fwft_pop3 got=%b/%0d exp=1/0", f_empty, f_count); end
    endtask

    task automatic test_std_basic();
        std_write(8'h11);
        checks++; if (s_empty !== 1'b0 || s_count !== 5'd1 || s_ae !== 1'b1) begin failures++; $display("FAIL std_first_wr got=%b/%0d/%b exp=0/1/1", s_empty, s_count, s_ae); end
        std_write(8'h22);
        std_write(8'h33);
        checks++; if (s_count !== 5'd3 || s_ae !== 1'b0) begin failures++; $display("FAIL std_count3 got=%0d/%b exp=3/0", s_count, s_ae); end
        s_rd = 1'b1;
        tick();
        checks++; if (s_dout !== 8'h00 || s_count !== 5'd2) begin failures++; $display("FAIL std_rd_lat got=%h/%0d exp=00/2", s_dout, s_count); end
        tick();
        checks++; if (s_dout !== 8'h11) begin failures++; $display("FAIL std_rd0 got=%h exp=11", s_dout); end
        tick();
        s_rd = 1'b0;
        checks++; if (s_dout !== 8'h22 || s_empty !== 1'b1 || s_count !== 5'd0) begin failures++; $display("FAIL std_rd1 got=%h/%b/%0d exp=22/1/0", s_dout, s_empty, s_count); end
        tick();
        checks++; if (s_dout !== 8'h33) begin failures++; $display("FAIL std_rd2 got=%h exp=33", s_dout); end
    endtask

    task automatic test_underflow();
        s_rd = 1'b1;
        tick();
        s_rd = 1'b0;
        checks++; if (s_udf !== 1'b1 || s_count !== 5'd0) begin failures++; $display("FAIL udf_pulse got=%b/%0d exp=1/0", s_udf, s_count); end
        tick();
        checks++; if (s_udf !== 1'b0 || s_dout !== 8'h33) begin failures++; $display("FAIL udf_end got=%b/%h exp=0/33", s_udf, s_dout); end
        s_wr = 1'b1; s_rd = 1'b1; s_din = 8'h44;
        tick();
        s_wr = 1'b0; s_rd = 1'b0;
        checks++; if (s_udf !== 1'b1 || s_count !== 5'd1 || s_empty !== 1'b0) begin failures++; $display("FAIL wr_rd_empty got=%b/%0d/%b exp=1/1/0", s_udf, s_count, s_empty); end
        s_rd = 1'b1;
        tick();
        s_rd = 1'b0;
        tick();
        checks++; if (s_dout !== 8'h44 || s_count !== 5'd0) begin failures++; $display("FAIL wr_rd_empty_data got=%h/%0d exp=44/0", s_dout, s_count); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            std_write(8'h80 + 8'(i));
            checks++; if (s_count !== 5'(i + 1) || s_af !== (i + 1 >= 14) || s_ae !== (i + 1 <= 2)) begin failures++; $display("FAIL fill_%0d got=%0d/%b/%b exp=%0d/%b/%b", i, s_count, s_af, s_ae, i + 1, (i + 1 >= 14), (i + 1 <= 2)); end
        end
        checks++; if (s_full !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", s_full); end
        std_write(8'hEE);
        checks++; if (s_ovf !== 1'b1 || s_count !== 5'd16) begin failures++; $display("FAIL ovf_pulse got=%b/%0d exp=1/16", s_ovf, s_count); end
        tick();
        checks++; if (s_ovf !== 1'b0) begin failures++; $display("FAIL ovf_end got=%b exp=0", s_ovf); end
        s_wr = 1'b1; s_rd = 1'b1; s_din = 8'h90;
        tick();
        s_wr = 1'b0; s_rd = 1'b0;
        checks++; if (s_count !== 5'd16 || s_full !== 1'b1 || s_ovf !== 1'b0) begin failures++; $display("FAIL full_wr_rd got=%0d/%b/%b exp=16/1/0", s_count, s_full, s_ovf); end
        tick();
        checks++; if (s_dout !== 8'h80) begin failures++; $display("FAIL full_wr_rd_data got=%h exp=80", s_dout); end
        s_rd = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            checks++; if (s_dout !== 8'h80 + 8'(k - 1)) begin failures++; $display("FAIL drain_%0d got=%h exp=%h", k, s_dout, 8'h80 + 8'(k - 1)); end
        end
        s_rd = 1'b0;
        tick();
        checks++; if (s_dout !== 8'h90 || s_empty !== 1'b1 || s_count !== 5'd0) begin failures++; $display("FAIL drain_last got=%h/%b/%0d exp=90/1/0", s_dout, s_empty, s_count); end
    endtask

    // Scoreboard: exp_q mirrors FIFO contents; a popped word is expected on data_o one edge later.
    task automatic test_random_stream();
        logic [7:0] exp_q[$];
        logic [7:0] rd_hold, popped;
        bit         rd_pend, rd_ok_m, wr_ok_m, w, r;
        int         written, cyc;
        rd_pend = 0; written = 0; cyc = 0; rd_hold = '0; popped = '0;
        while ((written < 100 || exp_q.size() > 0 || rd_pend) && cyc < 3000) begin
            w = (written < 100) && ($urandom_range(0, 3) != 0);
            r = (written >= 100) || ($urandom_range(0, 1) == 1);
            rd_ok_m = r && (exp_q.size() > 0);
            wr_ok_m = w && (exp_q.size() < 16 || rd_ok_m);
            s_wr = w; s_rd = r; s_din = 8'($urandom_range(0, 255));
            if (rd_ok_m) popped = exp_q.pop_front();
            if (wr_ok_m) begin
                exp_q.push_back(s_din);
                written++;
            end
            tick();
            cyc++;
            checks++; if (s_count !== 5'(exp_q.size()) || s_empty !== (exp_q.size() == 0) || s_full !== (exp_q.size() == 16)) begin failures++; $display("FAIL stream_count cyc=%0d got=%0d/%b/%b exp=%0d", cyc, s_count, s_empty, s_full, exp_q.size()); end
            if (rd_pend) begin
                checks++; if (s_dout !== rd_hold) begin failures++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", cyc, s_dout, rd_hold); end
            end
            rd_pend = rd_ok_m;
            rd_hold = popped;
        end
        s_wr = 1'b0; s_rd = 1'b0;
        checks++; if (cyc >= 3000) begin failures++; $display("FAIL stream_timeout got=%0d exp<3000", cyc); end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 5; i++) std_write(8'h51 + 8'(i));
        s_rd = 1'b1;
        tick();
        s_rd = 1'b0;
        tick();
        checks++; if (s_dout !== 8'h51 || s_count !== 5'd4) begin failures++; $display("FAIL clr_pre got=%h/%0d exp=51/4", s_dout, s_count); end
        std_write(8'h56);
        s_clear = 1'b1; s_wr = 1'b1; s_din = 8'h77;
        tick();
        s_clear = 1'b0; s_wr = 1'b0;
        checks++; if (s_count !== 5'd0 || {s_empty, s_full, s_ae, s_af, s_ovf, s_udf} !== 6'b101000) begin failures++; $display("FAIL clr_state got=%0d/%b exp=0/101000", s_count, {s_empty, s_full, s_ae, s_af, s_ovf, s_udf}); end
        checks++; if (s_dout !== 8'h51) begin failures++; $display("FAIL clr_data got=%h exp=51", s_dout); end
        tick();
        checks++; if (s_ovf !== 1'b0 || s_count !== 5'd0) begin failures++; $display("FAIL clr_after got=%b/%0d exp=0/0", s_ovf, s_count); end
        std_write(8'h60);
        s_rd = 1'b1;
        tick();
        s_rd = 1'b0;
        tick();
        checks++; if (s_dout !== 8'h60 || s_count !== 5'd0) begin failures++; $display("FAIL clr_reuse got=%h/%0d exp=60/0", s_dout, s_count); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) std_write(8'hC0 + 8'(i));
        s_wr = 1'b1; s_din = 8'hC3;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (s_count !== 5'd0 || {s_empty, s_full, s_ae, s_af, s_ovf, s_udf} !== 6'b101000 || s_dout !== 8'h00) begin failures++; $display("FAIL midrst got=%0d/%b/%h exp=0/101000/00", s_count, {s_empty, s_full, s_ae, s_af, s_ovf, s_udf}, s_dout); end
        s_wr = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (s_count !== 5'd0 || s_empty !== 1'b1) begin failures++; $display("FAIL midrst_release got=%0d/%b exp=0/1", s_count, s_empty); end
    endtask

    initial begin
        test_reset();
        test_fwft();
        test_std_basic();
        test_underflow();
        test_full();
        test_random_stream();
        test_clear();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
